// File: rtl/mul_seq_64.sv
// Iterative shift-add multiplier: low 64 bits of op_a*op_b, one multiplier bit per cycle.
// Optional MUL_SEQ_EARLY_EXIT_EN ends the operation once no set multiplier bits remain.

module adder_64 (
   input  logic [63:0] a,
   input  logic [63:0] b,
   output logic [63:0] sum
);
   // Carry out of bit 63 is dropped, so the sum wraps mod 2^64.
   assign sum = a + b;
endmodule

module mul_seq_64 #(
   parameter int ITERS = 64
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic        flush,
   input  logic [63:0] op_a,
   input  logic [63:0] op_b,
   output logic        ready,
   output logic        busy,
   output logic        done,
   output logic [63:0] result
);

   localparam logic [63:0] MASK = (ITERS >= 64) ? '1 : ((64'd1 << ITERS) - 64'd1);
   localparam logic [6:0]  LAST = 7'(ITERS - 1);

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t      state, state_nxt;
   logic [63:0] acc, mcand, mplier;
   logic [6:0]  count;
   logic [63:0] sum, acc_upd, mplier_upd;
   logic        last, accept;

   adder_64 u_add (
      .a   (acc),
      .b   (mcand),
      .sum (sum)
   );

   assign acc_upd    = mplier[0] ? sum : acc;
   assign mplier_upd = mplier >> 1;

`ifdef MUL_SEQ_EARLY_EXIT_EN
   assign last = (count == LAST) || (mplier_upd == '0);
`else
   assign last = (count == LAST);
`endif

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      accept    = 1'b0;
      case (state)
         IDLE: begin
            if (start && !flush) begin
               state_nxt = BUSY;
               accept    = 1'b1;
            end
         end
         BUSY: begin
            if (flush)     state_nxt = IDLE;
            else if (last) state_nxt = DONE;
         end
         DONE: begin
            if (start && !flush) begin
               state_nxt = BUSY;
               accept    = 1'b1;
            end else begin
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         acc    <= '0;
         mcand  <= '0;
         mplier <= '0;
         count  <= '0;
         result <= '0;
      end else if (accept) begin
         acc    <= '0;
         mcand  <= op_a;
         mplier <= op_b & MASK;
         count  <= '0;
      end else if (state == BUSY && !flush) begin
         acc    <= acc_upd;
         mcand  <= mcand << 1;
         mplier <= mplier_upd;
         count  <= count + 7'd1;
         // Capture includes this cycle's add, so result is final at DONE entry.
         if (last) result <= acc_upd;
      end
   end

   assign ready = (state == IDLE) || (state == DONE);
   assign busy  = (state == BUSY);
   assign done  = (state == DONE);

endmodule

// File: tb/tb_mul_seq_64.sv
// Scoreboard bench for mul_seq_64: ITERS=64 and ITERS=32 instances share stimulus.
// Expected latency follows MUL_SEQ_EARLY_EXIT_EN when the bench is built with it.

module tb_mul_seq_64;

   logic        clk = 1'b0;
   logic        reset, start, flush;
   logic [63:0] op_a, op_b;
   logic        ready, busy, done;
   logic [63:0] result;
   logic        ready32, busy32, done32;
   logic [63:0] result32;

   typedef struct {
      logic [63:0] res;
      int          lat;
   } exp_t;

   exp_t sb[$];
   int   n_chk  = 0;
   int   n_fail = 0;

   always #5 clk = ~clk;

   mul_seq_64 #(.ITERS(64)) dut (
      .clk(clk), .reset(reset), .start(start), .flush(flush),
      .op_a(op_a), .op_b(op_b),
      .ready(ready), .busy(busy), .done(done), .result(result)
   );

   mul_seq_64 #(.ITERS(32)) dut32 (
      .clk(clk), .reset(reset), .start(start), .flush(flush),
      .op_a(op_a), .op_b(op_b),
      .ready(ready32), .busy(busy32), .done(done32), .result(result32)
   );

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=0x%016h exp=0x%016h", tag, got, exp);
      end
   endtask

   function automatic logic [63:0] msk(input logic [63:0] b, input int iters);
      logic [63:0] m;
      m = (iters >= 64) ? {64{1'b1}} : ((64'd1 << iters) - 64'd1);
      return b & m;
   endfunction

   function automatic int exp_lat(input logic [63:0] b, input int iters);
`ifdef MUL_SEQ_EARLY_EXIT_EN
      logic [63:0] m;
      int l;
      m = msk(b, iters);
      l = 1;
      for (int i = 0; i < 64; i++) if (m[i]) l = i + 1;
      return l;
`else
      return iters;
`endif
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [63:0] a, input logic [63:0] b, input int iters);
      exp_t e;
      e.res = a * msk(b, iters);
      e.lat = exp_lat(b, iters);
      sb.push_back(e);
   endtask

   task automatic launch(input logic [63:0] a, input logic [63:0] b, input bit w32);
      op_a  = a;
      op_b  = b;
      start = 1'b1;
      push(a, b, w32 ? 32 : 64);
      step();
      start = 1'b0;
   endtask

   task automatic finish_op(input bit w32, input string tag);
      exp_t e;
      int   lat;
      lat = 0;
      while (!(w32 ? done32 : done) && lat < 300) begin
         step();
         lat++;
      end
      if (sb.size() == 0) begin
         chk({tag, "_sb_empty"}, 64'd1, 64'd0);
      end else begin
         e = sb.pop_front();
         chk({tag, "_lat"}, 64'(lat), 64'(e.lat));
         chk({tag, "_res"}, w32 ? result32 : result, e.res);
      end
   endtask

   task automatic issue(input logic [63:0] a, input logic [63:0] b, input bit w32, input string tag);
      launch(a, b, w32);
      finish_op(w32, tag);
   endtask

   task automatic quiet(input int n, input string tag);
      int seen;
      seen = 0;
      for (int i = 0; i < n; i++) begin
         step();
         if (done) seen++;
      end
      chk(tag, 64'(seen), 64'd0);
   endtask

   initial begin
      #2000000;
      $display("FAIL global_timeout got=running exp=finished");
      $fatal(1, "timeout");
   end

   initial begin
      reset = 1'b1; start = 1'b0; flush = 1'b0; op_a = '0; op_b = '0;
      repeat (3) step();
      reset = 1'b0;
      chk("rst_ready",  64'(ready),  64'd1);
      chk("rst_busy",   64'(busy),   64'd0);
      chk("rst_done",   64'(done),   64'd0);
      chk("rst_result", result,      64'd0);

      // Basic product and return to IDLE
      launch(64'd3, 64'd5, 1'b0);
      chk("acc_busy", 64'(busy), 64'd1);
      chk("acc_ready", 64'(ready), 64'd0);
      finish_op(1'b0, "m3x5");
      chk("m3x5_ready_done", 64'(ready), 64'd1);
      step();
      chk("m3x5_done_clr", 64'(done), 64'd0);
      chk("m3x5_ready_idle", 64'(ready), 64'd1);

      issue(64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 1'b0, "wrap");
      issue(64'h8000_0000_0000_0000, 64'd2, 1'b0, "msb");
      issue(64'd0, 64'hDEAD_BEEF, 1'b0, "a_zero");
      issue(64'h1234, 64'd0, 1'b0, "b_zero");
      for (int i = 0; i < 4; i++)
         issue({$urandom, $urandom}, {$urandom, $urandom}, 1'b0, "rand");

      // Flush mid-operation leaves the previous result
      issue(64'd3, 64'd5, 1'b0, "pre_flush");
      step();
      op_a = 64'd9; op_b = 64'd9; start = 1'b1;
      step();
      start = 1'b0;
`ifdef MUL_SEQ_EARLY_EXIT_EN
      step();
`else
      repeat (9) step();
`endif
      flush = 1'b1;
      step();
      flush = 1'b0;
      chk("flush_ready",  64'(ready), 64'd1);
      chk("flush_busy",   64'(busy),  64'd0);
      chk("flush_result", result,     64'd15);
      quiet(80, "flush_no_done");
      chk("flush_result_hold", result, 64'd15);

      // Start held through BUSY is ignored; DONE-cycle start issues back-to-back
      launch(64'd3, 64'd5, 1'b0);
      start = 1'b1;
      op_a = 64'd100; op_b = 64'd100;
      finish_op(1'b0, "held");
      op_a = 64'd7; op_b = 64'd6;
      push(64'd7, 64'd6, 64);
      step();
      start = 1'b0;
      chk("b2b_busy", 64'(busy), 64'd1);
      finish_op(1'b0, "b2b");

      // W-form instance ignores op_b[63:32]
      flush = 1'b1; step(); flush = 1'b0;
      issue(64'd5, 64'h0000_0001_0000_0002, 1'b1, "w32");
      issue(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_0000_0003, 1'b1, "w32_wrap");
      flush = 1'b1; step(); flush = 1'b0;
      chk("flush_idle32", 64'(ready32), 64'd1);

      // Reset mid-operation
      op_a = 64'd3; op_b = 64'h8000_0000_0000_0005; start = 1'b1;
      step();
      start = 1'b0;
      repeat (1) step();
      reset = 1'b1;
      step();
      reset = 1'b0;
      chk("mid_rst_ready",  64'(ready), 64'd1);
      chk("mid_rst_busy",   64'(busy),  64'd0);
      chk("mid_rst_done",   64'(done),  64'd0);
      chk("mid_rst_result", result,     64'd0);
      quiet(80, "mid_rst_no_done");

      issue(64'd11, 64'd13, 1'b0, "post_rst");

      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end

endmodule
